// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: registers the ALU result and runs one ld/st data-memory transaction at a time.
// Optional MA_TIMEOUT_EN adds a watchdog that aborts a stuck ld/st after TMO_CYC cycles.
module mem_access_stage #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 4
`ifdef MA_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 64
`endif
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] st_data,
    input  logic              is_ld,
    input  logic              is_st,
    input  logic              is_wb,
    input  logic [RD_W-1:0]   rd_idx,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_en,
    output logic              ma_err,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // (or req and gnt) are both high; the sender holds its payload stable
    // until that edge. All outputs come straight from flops.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              ex_ready_q, ex_ready_d;
    logic              is_ld_q, is_ld_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic              wb_en_q, wb_en_d;
    logic              ma_err_q, ma_err_d;
    logic              mem_done;

`ifdef MA_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
`endif

    // Response completes the transaction either together with gnt in REQ, or later in WAIT.
    assign mem_done = ((state_q == REQ) && mem_gnt && mem_rvalid) ||
                      ((state_q == WAIT) && mem_rvalid);

    always_comb begin
        state_d     = state_q;
        is_ld_d     = is_ld_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = wb_valid_q;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        wb_en_d     = wb_en_q;
        ma_err_d    = ma_err_q;

        case (state_q)
            IDLE: begin
                if (ex_valid && ex_ready_q) begin
                    wb_rd_d = rd_idx;
                    if (is_ld || is_st) begin
                        if (alu_result[1:0] == 2'b00) begin
                            state_d     = REQ;
                            is_ld_d     = is_ld;
                            mem_req_d   = 1'b1;
                            mem_we_d    = ~is_ld;
                            mem_addr_d  = alu_result;
                            mem_wdata_d = st_data;
                        end else begin
                            state_d    = OUT;
                            ma_err_d   = 1'b1;
                            wb_valid_d = 1'b1;
                            wb_data_d  = alu_result;
                            wb_en_d    = 1'b0;
                        end
                    end else begin
                        state_d    = OUT;
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_result;
                        wb_en_d    = is_wb;
                    end
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    mem_req_d = 1'b0;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                mem_req_d = 1'b0;
            end
            OUT: begin
                if (wb_ready) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (mem_done) begin
            state_d    = OUT;
            mem_req_d  = 1'b0;
            wb_valid_d = 1'b1;
            wb_data_d  = is_ld_q ? mem_rdata : mem_addr_q;
            wb_en_d    = is_ld_q;
        end

`ifdef MA_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        if (state_q == IDLE) begin
            tmo_cnt_d = '0;
        end else if ((state_q == REQ) || (state_q == WAIT)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            if (!mem_done && (tmo_cnt_q == TMO_W'(TMO_CYC - 1))) begin
                state_d    = OUT;
                ma_err_d   = 1'b1;
                mem_req_d  = 1'b0;
                wb_valid_d = 1'b1;
                wb_en_d    = 1'b0;
                wb_data_d  = '1;
            end
        end
`else
        // Without the watchdog the stage waits as long as memory takes.
`endif

        ex_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ex_ready_q  <= 1'b0;
            is_ld_q     <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= '0;
            wb_en_q     <= 1'b0;
            ma_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ex_ready_q  <= ex_ready_d;
            is_ld_q     <= is_ld_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            wb_en_q     <= wb_en_d;
            ma_err_q    <= ma_err_d;
        end
    end

`ifdef MA_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`endif

    assign ex_ready  = ex_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign wb_rd     = wb_rd_q;
    assign wb_en     = wb_en_q;
    assign ma_err    = ma_err_q;
    assign dbg_state = state_q;

endmodule
